// File: rtl/nes_joypad.sv
// NES controller port: HPS-written button registers presented to the CPU through
// the $4016/$4017 strobe-and-serial-shift protocol, with a latch-event counter.
module nes_joypad #(
  parameter logic [15:0] JOY0_ADDR = 16'h4016,
  parameter logic [15:0] JOY1_ADDR = 16'h4017,
  parameter logic [7:0]  OPEN_BUS  = 8'h40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [7:0]  avs_writedata,
  input  logic        avs_read,
  output logic [7:0]  avs_readdata,
  input  logic        cpu_sel,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid
);

  logic [7:0] btn0_q, btn0_d;
  logic [7:0] btn1_q, btn1_d;
  logic [7:0] sh0_q, sh0_d;
  logic [7:0] sh1_q, sh1_d;
  logic       strobe_q, strobe_d;
  logic [3:0] latch_cnt_q, latch_cnt_d;

  // Decoded CPU request, registered so it executes on the following edge.
  logic       rd0_q, rd0_d;
  logic       rd1_q, rd1_d;
  logic       wr_q, wr_d;
  logic       wbit_q, wbit_d;

  logic [7:0] avs_rdata_q, avs_rdata_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic       cpu_rvalid_q, cpu_rvalid_d;

  logic       unused_wdata;
  assign unused_wdata = ^cpu_wdata[7:1];

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    btn0_d       = btn0_q;
    btn1_d       = btn1_q;
    sh0_d        = sh0_q;
    sh1_d        = sh1_q;
    strobe_d     = strobe_q;
    latch_cnt_d  = latch_cnt_q;
    avs_rdata_d  = avs_rdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_rvalid_d = 1'b0;

    if (avs_write) begin
      unique case (avs_address)
        2'd0:    btn0_d = avs_writedata;
        2'd1:    btn1_d = avs_writedata;
        default: ;
      endcase
    end

    if (avs_read) begin
      unique case (avs_address)
        2'd0:    avs_rdata_d = btn0_q;
        2'd1:    avs_rdata_d = btn1_q;
        2'd2:    avs_rdata_d = {3'b000, latch_cnt_q, strobe_q};
        default: avs_rdata_d = 8'h00;
      endcase
    end

    rd0_d  = cpu_sel && cpu_rw && (cpu_addr == JOY0_ADDR);
    rd1_d  = cpu_sel && cpu_rw && (cpu_addr == JOY1_ADDR);
    wr_d   = cpu_sel && !cpu_rw && (cpu_addr == JOY0_ADDR);
    wbit_d = cpu_wdata[0];

    if (wr_q) begin
      strobe_d = wbit_q;
      if (strobe_q && !wbit_q) latch_cnt_d = latch_cnt_q + 4'd1;
    end

    // The falling-edge write still sees strobe_q high, so this load is the latch.
    if (strobe_q) begin
      sh0_d = btn0_q;
      sh1_d = btn1_q;
    end

    if (rd0_q) begin
      cpu_rvalid_d = 1'b1;
      cpu_rdata_d  = {OPEN_BUS[7:1], strobe_q ? btn0_q[0] : sh0_q[0]};
      if (!strobe_q) sh0_d = {1'b1, sh0_q[7:1]};
    end else if (rd1_q) begin
      cpu_rvalid_d = 1'b1;
      cpu_rdata_d  = {OPEN_BUS[7:1], strobe_q ? btn1_q[0] : sh1_q[0]};
      if (!strobe_q) sh1_d = {1'b1, sh1_q[7:1]};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn0_q       <= 8'h00;
      btn1_q       <= 8'h00;
      sh0_q        <= 8'hFF;
      sh1_q        <= 8'hFF;
      strobe_q     <= 1'b0;
      latch_cnt_q  <= 4'd0;
      rd0_q        <= 1'b0;
      rd1_q        <= 1'b0;
      wr_q         <= 1'b0;
      wbit_q       <= 1'b0;
      avs_rdata_q  <= 8'h00;
      cpu_rdata_q  <= 8'h00;
      cpu_rvalid_q <= 1'b0;
    end else begin
      btn0_q       <= btn0_d;
      btn1_q       <= btn1_d;
      sh0_q        <= sh0_d;
      sh1_q        <= sh1_d;
      strobe_q     <= strobe_d;
      latch_cnt_q  <= latch_cnt_d;
      rd0_q        <= rd0_d;
      rd1_q        <= rd1_d;
      wr_q         <= wr_d;
      wbit_q       <= wbit_d;
      avs_rdata_q  <= avs_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  assign avs_readdata = avs_rdata_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_rvalid   = cpu_rvalid_q;

endmodule

// File: tb/tb_nes_joypad.sv
// Directed bench for nes_joypad: a transaction-level pad model predicts every
// CPU read and its arrival cycle; a negedge process compares the DUT against it.
module tb_nes_joypad;

  localparam logic [15:0] J0 = 16'h4016;
  localparam logic [15:0] J1 = 16'h4017;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [7:0]  avs_writedata;
  logic        avs_read;
  logic [7:0]  avs_readdata;
  logic        cpu_sel;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;

  nes_joypad dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .cpu_sel       (cpu_sel),
    .cpu_rw        (cpu_rw),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_rvalid    (cpu_rvalid)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pad model: button bytes, strobe, latch count, latched byte and read index.
  logic [7:0] m_btn [2];
  logic [7:0] m_lat [2];
  int         m_idx [2];
  logic       m_strobe;
  int         m_cnt;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;
  exp_t       expq[$];
  logic [7:0] seen[$];
  logic [7:0] last_rd;

  function automatic logic [7:0] m_status();
    logic [3:0] c;
    c = m_cnt[3:0];
    return {3'b000, c, m_strobe};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_btn[p] = 8'h00;
      m_lat[p] = 8'hFF;
      m_idx[p] = 8;
    end
    m_strobe = 1'b0;
    m_cnt    = 0;
    last_rd  = 8'h00;
    expq.delete();
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_rvalid", {7'b0, cpu_rvalid}, 8'h00);
      check("rst_rdata", cpu_rdata, 8'h00);
    end else begin
      logic ev;
      ev = (expq.size() > 0) && (expq[0].due == cyc);
      check("rvalid", {7'b0, cpu_rvalid}, {7'b0, ev});
      if (ev) begin
        exp_t e;
        e = expq.pop_front();
        check("rdata", cpu_rdata, e.d);
        seen.push_back(cpu_rdata);
        last_rd = e.d;
      end else begin
        check("rdata_hold", cpu_rdata, last_rd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    int   p;
    logic b;
    exp_t e;
    cpu_sel  = 1'b1;
    cpu_rw   = 1'b1;
    cpu_addr = a;
    p = (a == J0) ? 0 : (a == J1) ? 1 : -1;
    if (p >= 0) begin
      if (m_strobe) b = m_btn[p][0];
      else begin
        b = (m_idx[p] < 8) ? m_lat[p][m_idx[p]] : 1'b1;
        m_idx[p]++;
      end
      e.d   = 8'h40 | {7'b0, b};
      e.due = cyc + 2;
      expq.push_back(e);
    end
    step();
    cpu_sel = 1'b0;
    cpu_rw  = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_sel   = 1'b1;
    cpu_rw    = 1'b0;
    cpu_addr  = a;
    cpu_wdata = d;
    if (a == J0) begin
      if (m_strobe && !d[0]) begin
        m_lat[0] = m_btn[0];
        m_lat[1] = m_btn[1];
        m_idx[0] = 0;
        m_idx[1] = 0;
        m_cnt    = (m_cnt + 1) % 16;
      end
      m_strobe = d[0];
    end
    step();
    cpu_sel = 1'b0;
  endtask

  task automatic avs_wr(input logic [1:0] a, input logic [7:0] d);
    avs_write     = 1'b1;
    avs_address   = a;
    avs_writedata = d;
    if (a < 2'd2) m_btn[a] = d;
    step();
    avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [1:0] a, input logic [7:0] exp, input string name);
    avs_read    = 1'b1;
    avs_address = a;
    step();
    avs_read = 1'b0;
    check(name, avs_readdata, exp);
  endtask

  task automatic check_seen(input string name, input logic [7:0] lit[$]);
    check({name, "_count"}, 8'(seen.size()), 8'(lit.size()));
    for (int i = 0; i < lit.size(); i++) check(name, seen[i], lit[i]);
  endtask

  initial begin
    reset_n = 1'b0;
    avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
    cpu_sel = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state and unlatched first read.
    avs_rd(2'd2, 8'h00, "rst_status");
    seen.delete();
    cpu_rd(J0);
    idle(3);
    check_seen("first_read", '{8'h41});

    // Latch A5 and read ten times back to back.
    avs_wr(2'd0, 8'hA5);
    cpu_wr(J0, 8'h01);
    cpu_wr(J0, 8'h00);
    seen.delete();
    repeat (10) cpu_rd(J0);
    idle(3);
    check_seen("a5_seq", '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h41, 8'h41, 8'h41});
    avs_rd(2'd2, 8'h02, "status_after_latch");
    avs_rd(2'd0, 8'hA5, "avs_btn0");

    // Strobe held high: reads follow the live button bit, no shifting.
    avs_wr(2'd0, 8'h01);
    cpu_wr(J0, 8'h01);
    seen.delete();
    repeat (3) cpu_rd(J0);
    avs_wr(2'd0, 8'h00);
    cpu_rd(J0);
    idle(3);
    check_seen("strobe_high", '{8'h41, 8'h41, 8'h41, 8'h40});
    avs_rd(2'd2, m_status(), "status_strobe_high");

    // Independent pads: interleave $4017 and $4016 reads.
    avs_wr(2'd1, 8'h80);
    avs_wr(2'd0, 8'h3C);
    cpu_wr(J0, 8'h01);
    cpu_wr(J0, 8'h00);
    seen.delete();
    for (int i = 0; i < 15; i++) cpu_rd((i % 2 == 0) ? J1 : J0);
    idle(3);
    check_seen("interleave", '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h40, 8'h41,
                               8'h40, 8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h41});

    // Sixteen falling edges wrap the counter back to its previous value.
    for (int i = 0; i < 16; i++) begin
      cpu_wr(J0, 8'h01);
      cpu_wr(J0, 8'h00);
    end
    idle(2);
    avs_rd(2'd2, 8'h04, "status_wrap");
    avs_rd(2'd2, m_status(), "status_wrap_model");
    cpu_wr(J1, 8'h01);
    cpu_rd(16'h4018);
    idle(3);
    avs_rd(2'd2, 8'h04, "j1_write_ignored");
    avs_wr(2'd2, 8'hFF);
    avs_wr(2'd3, 8'hFF);
    avs_rd(2'd0, 8'h3C, "avs_btn0_kept");
    avs_rd(2'd1, 8'h80, "avs_btn1_kept");
    avs_rd(2'd3, 8'h00, "avs_reserved");

    // Reset in the middle of a latched sequence.
    avs_wr(2'd0, 8'hA5);
    cpu_wr(J0, 8'h01);
    cpu_wr(J0, 8'h00);
    seen.delete();
    repeat (3) cpu_rd(J0);
    idle(3);
    check_seen("pre_reset", '{8'h41, 8'h40, 8'h41});
    avs_rd(2'd2, 8'h06, "status_pre_reset");
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_rdata", cpu_rdata, 8'h00);
    check("async_rst_rvalid", {7'b0, cpu_rvalid}, 8'h00);
    check("async_rst_avs", avs_readdata, 8'h00);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    seen.delete();
    cpu_rd(J0);
    idle(3);
    check_seen("post_reset", '{8'h41});
    avs_rd(2'd2, 8'h00, "status_post_reset");
    avs_rd(2'd0, 8'h00, "btn0_post_reset");

    check("reads_drained", 8'(expq.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
